decode_stage: RTL
=================

Name: decode_stage

Overview:
- LC3 pipeline decode stage; the producer that feeds the execute stage.
- Registers the fetched instruction and NPC, then generates execute/writeback/memory control words for execute to consume.
- Tracks the destination registers of the two older in-flight instructions and raises the ALU/memory bypass flags that execute uses to select forwarded operands.
- One-cycle latency. Supports stall (enable) and flush (bubble insertion).

Parameters:
- NOP_IR, 16'h0000, IR value loaded when a bubble is inserted (decodes as BR with nzp=000, i.e. never taken).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- enable_decode  input  1  1 = advance stage; 0 = hold all outputs and history
- flush  input  1  1 = load bubble instead of instr_dout (ignored when enable_decode=0)
- instr_dout  input  16  instruction word from fetch
- npc_in  input  16  PC+1 of instr_dout
- ir  output  16  registered instruction
- npc_out  output  16  registered NPC
- e_control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- w_control  output  2  writeback select: 00 ALU, 01 memory data, 10 PC adder
- mem_control  output  1  1 = indirect access (LDI/STI)
- bypass_alu_1  output  1  SR1 sourced from execute-stage ALU result
- bypass_alu_2  output  1  SR2 sourced from execute-stage ALU result
- bypass_mem_1  output  1  SR1 sourced from memory-stage load data
- bypass_mem_2  output  1  SR2 sourced from memory-stage load data
- valid_out  output  1  0 when the current ir is a bubble

Behaviour:
- Reset (rst=1 at an edge): ir=NOP_IR, npc_out=0, e_control=0, w_control=0, mem_control=0, all bypass flags=0, valid_out=0, history cleared (both entries invalid, DR=0). rst takes priority over enable_decode and flush.
- Hold: when enable_decode=0, every output and the history stay unchanged.
- Advance (enable_decode=1, flush=0): ir<=instr_dout, npc_out<=npc_in, valid_out<=1, and controls are decoded from instr_dout.
- Advance with flush=1: ir<=NOP_IR, npc_out<=npc_in, valid_out<=0, controls and bypass flags=0.
- Decode table, opcode = instr[15:12], giving e_control / w_control / mem_control:
  - ADD: 000001 if instr[5]=0, else 000000 / 00 / 0
  - AND: 010001 if instr[5]=0, else 010000 / 00 / 0
  - NOT: 100000 / 00 / 0
  - BR: 000110 / 00 / 0
  - JMP: 001100 / 00 / 0
  - LD: 000110 / 01 / 0
  - LDR: 001000 / 01 / 0
  - LDI: 000110 / 01 / 1
  - LEA: 000110 / 10 / 0
  - ST: 000110 / 00 / 0
  - STR: 001000 / 00 / 0
  - STI: 000110 / 00 / 1
  - any other opcode: 000000 / 00 / 0, treated as no-write
- Register writers: ADD, AND, NOT, LEA, LD, LDR, LDI. DR = instr[11:9].
- History: 2-entry shift of {valid, is_alu, is_load, dr}.
  - Entry E describes the instruction now in execute, i.e. the current ir.
  - Entry M describes the instruction now in memory.
  - On every advance: M<=E, and E<=the new instruction's entry. A bubble shifts in as invalid.
  - On hold: no shift.
  - is_alu = ADD/AND/NOT. is_load = LD/LDR/LDI.
- Sources of the incoming instruction:
  - SR1 = instr[8:6]. Used by ADD, AND, NOT, LDR, STR, JMP.
  - SR2 = instr[2:0]. Used only by ADD/AND with instr[5]=0.
- Bypass flags, computed from the incoming instruction and the history before the shift, registered together with ir:
  - bypass_alu_n = 1 when srcN is used, E.valid, E.is_alu, and E.dr == srcN.
  - bypass_mem_n = 1 when srcN is used, M.valid, M.is_load, M.dr == srcN, and bypass_alu_n=0. The younger producer wins.
- Simultaneous events:
  - flush with enable_decode=1: the bubble wins.
  - rst with anything: reset wins.
  - SR1==SR2: both flags of the same kind may assert together.

Test Plan:
1. Reset: rst=1 for 2 cycles -> ir=0000, e_control=000000, all bypass=0, valid_out=0. Deassert rst, hold enable_decode=0 -> outputs unchanged.
2. Decode sweep with enable_decode=1:
   - instr 1263 (ADD R1,R1,#3) -> e_control=000000, w=00, mem=0.
   - A001 (LDI R0) -> e_control=000110, w=01, mem=1.
   - EA05 (LEA R5) -> w=10.
   - 6A42 (LDR) -> e_control=001000.
3. ALU bypass: 1401 (ADD R2,R0,R1) then 1682 (ADD R3,R2,R2) -> on the second output, bypass_alu_1=1, bypass_alu_2=1, bypass_mem_1=0, bypass_mem_2=0.
4. Memory bypass: 2403 (LD R2), then 1000, then 1682 (ADD R3,R2,R2) -> third output bypass_mem_1=1, bypass_mem_2=1, alu flags=0. Repeat with 1000 replaced by 14A0 (ADD R2,R2,#0) -> alu flags=1, mem flags=0.
5. Stall: present 1401, then 1682 with enable_decode=0 for 3 cycles, then enable -> outputs frozen during the stall, and the 1682 output still shows bypass_alu_1/2=1 (history did not shift).
6. Flush: 2403 (LD R2), then flush=1 for one cycle, then 1682 -> the flushed cycle gives valid_out=0 with controls=0. The 1682 output shows bypass_mem_1/2=1, because LD is now in M and the bubble is in E. With two bubbles between them -> all flags=0.

Source files
------------

// File: rtl/decode_stage.sv
// LC3 decode stage: registers IR/NPC, decodes execute/writeback/memory controls and
// raises operand bypass flags from a two-deep history of older in-flight writers.
module decode_stage #(
   parameter logic [15:0] NOP_IR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_decode,
   input  logic        flush,
   input  logic [15:0] instr_dout,
   input  logic [15:0] npc_in,
   output logic [15:0] ir,
   output logic [15:0] npc_out,
   output logic [5:0]  e_control,
   output logic [1:0]  w_control,
   output logic        mem_control,
   output logic        bypass_alu_1,
   output logic        bypass_alu_2,
   output logic        bypass_mem_1,
   output logic        bypass_mem_2,
   output logic        valid_out
);

   localparam logic [3:0] OpBr  = 4'b0000;
   localparam logic [3:0] OpAdd = 4'b0001;
   localparam logic [3:0] OpLd  = 4'b0010;
   localparam logic [3:0] OpSt  = 4'b0011;
   localparam logic [3:0] OpAnd = 4'b0101;
   localparam logic [3:0] OpLdr = 4'b0110;
   localparam logic [3:0] OpStr = 4'b0111;
   localparam logic [3:0] OpNot = 4'b1001;
   localparam logic [3:0] OpLdi = 4'b1010;
   localparam logic [3:0] OpSti = 4'b1011;
   localparam logic [3:0] OpJmp = 4'b1100;
   localparam logic [3:0] OpLea = 4'b1110;

   // History of older writers: E = instruction now in execute, M = now in memory.
   logic       e_valid, e_alu, e_load;
   logic [2:0] e_dr;
   logic       m_valid, m_load;
   logic [2:0] m_dr;

   logic [3:0] opcode;
   logic [2:0] dr, sr1, sr2;
   logic [5:0] dec_e;
   logic [1:0] dec_w;
   logic       dec_mem, is_alu, is_load, writes, sr1_used, sr2_used;
   logic       byp_alu_1, byp_alu_2, byp_mem_1, byp_mem_2;

   always_comb begin
      opcode   = instr_dout[15:12];
      dr       = instr_dout[11:9];
      sr1      = instr_dout[8:6];
      sr2      = instr_dout[2:0];
      dec_e    = 6'b000000;
      dec_w    = 2'b00;
      dec_mem  = 1'b0;
      is_alu   = 1'b0;
      is_load  = 1'b0;
      writes   = 1'b0;
      sr1_used = 1'b0;
      sr2_used = 1'b0;
      case (opcode)
         OpAdd: begin
            dec_e    = instr_dout[5] ? 6'b000000 : 6'b000001;
            is_alu   = 1'b1;
            writes   = 1'b1;
            sr1_used = 1'b1;
            sr2_used = ~instr_dout[5];
         end
         OpAnd: begin
            dec_e    = instr_dout[5] ? 6'b010000 : 6'b010001;
            is_alu   = 1'b1;
            writes   = 1'b1;
            sr1_used = 1'b1;
            sr2_used = ~instr_dout[5];
         end
         OpNot: begin
            dec_e    = 6'b100000;
            is_alu   = 1'b1;
            writes   = 1'b1;
            sr1_used = 1'b1;
         end
         OpBr:  dec_e = 6'b000110;
         OpJmp: begin
            dec_e    = 6'b001100;
            sr1_used = 1'b1;
         end
         OpLd: begin
            dec_e   = 6'b000110;
            dec_w   = 2'b01;
            is_load = 1'b1;
            writes  = 1'b1;
         end
         OpLdr: begin
            dec_e    = 6'b001000;
            dec_w    = 2'b01;
            is_load  = 1'b1;
            writes   = 1'b1;
            sr1_used = 1'b1;
         end
         OpLdi: begin
            dec_e   = 6'b000110;
            dec_w   = 2'b01;
            dec_mem = 1'b1;
            is_load = 1'b1;
            writes  = 1'b1;
         end
         OpLea: begin
            dec_e  = 6'b000110;
            dec_w  = 2'b10;
            writes = 1'b1;
         end
         OpSt:  dec_e = 6'b000110;
         OpStr: begin
            dec_e    = 6'b001000;
            sr1_used = 1'b1;
         end
         OpSti: begin
            dec_e   = 6'b000110;
            dec_mem = 1'b1;
         end
         default: ;
      endcase
      // The execute-stage producer is younger, so it overrides the memory-stage load.
      byp_alu_1 = sr1_used && e_valid && e_alu && (e_dr == sr1);
      byp_alu_2 = sr2_used && e_valid && e_alu && (e_dr == sr2);
      byp_mem_1 = sr1_used && m_valid && m_load && (m_dr == sr1) && !byp_alu_1;
      byp_mem_2 = sr2_used && m_valid && m_load && (m_dr == sr2) && !byp_alu_2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir           <= NOP_IR;
         npc_out      <= 16'h0000;
         e_control    <= 6'b000000;
         w_control    <= 2'b00;
         mem_control  <= 1'b0;
         bypass_alu_1 <= 1'b0;
         bypass_alu_2 <= 1'b0;
         bypass_mem_1 <= 1'b0;
         bypass_mem_2 <= 1'b0;
         valid_out    <= 1'b0;
         e_valid      <= 1'b0;
         e_alu        <= 1'b0;
         e_load       <= 1'b0;
         e_dr         <= 3'd0;
         m_valid      <= 1'b0;
         m_load       <= 1'b0;
         m_dr         <= 3'd0;
      end else if (enable_decode) begin
         npc_out <= npc_in;
         m_valid <= e_valid;
         m_load  <= e_load;
         m_dr    <= e_dr;
         if (flush) begin
            ir           <= NOP_IR;
            e_control    <= 6'b000000;
            w_control    <= 2'b00;
            mem_control  <= 1'b0;
            bypass_alu_1 <= 1'b0;
            bypass_alu_2 <= 1'b0;
            bypass_mem_1 <= 1'b0;
            bypass_mem_2 <= 1'b0;
            valid_out    <= 1'b0;
            e_valid      <= 1'b0;
            e_alu        <= 1'b0;
            e_load       <= 1'b0;
            e_dr         <= 3'd0;
         end else begin
            ir           <= instr_dout;
            e_control    <= dec_e;
            w_control    <= dec_w;
            mem_control  <= dec_mem;
            bypass_alu_1 <= byp_alu_1;
            bypass_alu_2 <= byp_alu_2;
            bypass_mem_1 <= byp_mem_1;
            bypass_mem_2 <= byp_mem_2;
            valid_out    <= 1'b1;
            e_valid      <= writes;
            e_alu        <= is_alu;
            e_load       <= is_load;
            e_dr         <= dr;
         end
      end
   end

endmodule
